// File: rtl/pwm_fet_driver_array.sv
// N-channel complementary PWM FET driver with dead time, double-buffered duty,
// latched fault shutdown and a Wishbone register interface.
module pwm_fet_driver_array #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DT_W      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              fault_i,
    output logic [NUM_CH-1:0] pwm_hi_o,
    output logic [NUM_CH-1:0] pwm_lo_o,
    output logic              irq_o
);

    logic              en, irq_en, fault, wrap;
    logic [CNT_W-1:0]  period, cnt;
    logic [DT_W-1:0]   deadtime;
    logic [CNT_W-1:0]  shadow   [NUM_CH];
    logic [CNT_W-1:0]  duty_act [NUM_CH];
    logic [DT_W-1:0]   dt_q     [NUM_CH];
    logic [DT_W-1:0]   dt_cur   [NUM_CH];
    logic [NUM_CH-1:0] raw, raw_q;
    logic              en_q, fault_s1, fault_s2, fault_act, en_rise, wrap_evt;

    logic [31:0] offset, rd_data;
    logic [5:0]  widx;
    logic        hit, req, wr_req, fault_clr, wrap_clr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int unsigned b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    // Misaligned offsets are treated as unmapped.
    assign offset    = wbs_adr_i - BASE_ADDR;
    assign hit       = (offset[31:8] == '0) && (offset[1:0] == 2'b00);
    assign widx      = offset[7:2];
    assign req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr_req    = req & wbs_we_i & hit;
    assign fault_clr = wr_req & (widx == 6'd0) & wbs_sel_i[0] & wbs_dat_i[2];
    assign wrap_clr  = wr_req & (widx == 6'd3) & wbs_sel_i[0] & wbs_dat_i[1];

    always_comb begin
        rd_data = '0;
        if (hit) begin
            case (widx)
                6'd0: begin rd_data[0] = en; rd_data[1] = irq_en; end
                6'd1: rd_data[CNT_W-1:0] = period;
                6'd2: rd_data[DT_W-1:0] = deadtime;
                6'd3: begin rd_data[0] = fault; rd_data[1] = wrap; end
                default: begin
                    for (int unsigned n = 0; n < NUM_CH; n++)
                        if (widx == 6'(4 + n)) rd_data[CNT_W-1:0] = shadow[n];
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            en        <= 1'b0;
            irq_en    <= 1'b0;
            period    <= '0;
            deadtime  <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) shadow[n] <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rd_data : '0;
            if (wr_req) begin
                case (widx)
                    6'd0: begin
                        if (wbs_sel_i[0]) begin
                            en     <= wbs_dat_i[0];
                            irq_en <= wbs_dat_i[1];
                        end
                    end
                    6'd1: period   <= CNT_W'(merge(32'(period), wbs_dat_i, wbs_sel_i));
                    6'd2: deadtime <= DT_W'(merge(32'(deadtime), wbs_dat_i, wbs_sel_i));
                    default: begin
                        for (int unsigned n = 0; n < NUM_CH; n++)
                            if (widx == 6'(4 + n))
                                shadow[n] <= CNT_W'(merge(32'(shadow[n]), wbs_dat_i, wbs_sel_i));
                    end
                endcase
            end
        end
    end

    // >= so that a PERIOD shrunk below cnt wraps on the next cycle.
    assign wrap_evt = en & (cnt >= period);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) duty_act[n] <= '0;
        end else begin
            cnt <= (!en || wrap_evt) ? '0 : cnt + CNT_W'(1);
            for (int unsigned n = 0; n < NUM_CH; n++)
                if (!en || wrap_evt) duty_act[n] <= shadow[n];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            fault_s1 <= 1'b0;
            fault_s2 <= 1'b0;
            fault    <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            fault_s1 <= fault_i;
            fault_s2 <= fault_s1;
            if (fault_s2)       fault <= 1'b1;
            else if (fault_clr) fault <= 1'b0;
            if (wrap_evt)       wrap <= 1'b1;
            else if (wrap_clr)  wrap <= 1'b0;
        end
    end

    // Gating on the synchroniser output too keeps fault-to-gate-off within 3 cycles.
    assign fault_act = fault | fault_s2;
    assign en_rise   = en & ~en_q;

    always_comb begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            raw[n]    = en & ~fault_act & (cnt < duty_act[n]);
            dt_cur[n] = ((raw[n] != raw_q[n]) || en_rise) ? '0 : dt_q[n];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            raw_q    <= '0;
            en_q     <= 1'b0;
            pwm_hi_o <= '0;
            pwm_lo_o <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) dt_q[n] <= '0;
        end else begin
            raw_q <= raw;
            en_q  <= en;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                dt_q[n]     <= (dt_cur[n] < deadtime) ? dt_cur[n] + DT_W'(1) : deadtime;
                pwm_hi_o[n] <= raw[n] & (dt_cur[n] == deadtime);
                pwm_lo_o[n] <= en & ~fault_act & ~raw[n] & (dt_cur[n] == deadtime);
            end
        end
    end

    assign irq_o = irq_en & (fault | wrap);

endmodule

// File: tb/tb_pwm_fet_driver_array.sv
// Directed self-checking bench for pwm_fet_driver_array (NUM_CH=4, CNT_W=16, DT_W=8).
module tb_pwm_fet_driver_array;

    localparam int          NCH  = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]      sel = '0;
    logic [31:0]     adr = '0, wdat = '0;
    logic            ack;
    logic [31:0]     rdat;
    logic            fault_in = 1'b0;
    logic [NCH-1:0]  hi, lo;
    logic            irq;

    int checks = 0;
    int errors = 0;
    int hi_cnt[NCH];
    int lo_cnt[NCH];
    int overlap;
    int runs[$];
    int run_len = 0;

    always #5 clk = ~clk;

    pwm_fet_driver_array #(
        .NUM_CH(NCH),
        .CNT_W(16),
        .DT_W(8),
        .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .fault_i  (fault_in),
        .pwm_hi_o (hi),
        .pwm_lo_o (lo),
        .irq_o    (irq)
    );

    // High-pulse lengths on channel 0.
    always @(negedge clk) begin
        if (!rst_n) run_len = 0;
        else if (hi[0]) run_len++;
        else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        int lat;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 16);
        check("ack_latency", 32'(lat), 32'd1);
        rd = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0;
    endtask

    task automatic wb_wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, BASE + off, d, 4'hF, unused_rd);
    endtask

    task automatic wb_rd(input logic [31:0] off, output logic [31:0] rd);
        wb_xfer(1'b0, BASE + off, 32'h0, 4'hF, rd);
    endtask

    task automatic measure(input int n);
        for (int c = 0; c < NCH; c++) begin hi_cnt[c] = 0; lo_cnt[c] = 0; end
        overlap = 0;
        repeat (n) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                hi_cnt[c] += int'(hi[c]);
                lo_cnt[c] += int'(lo[c]);
                if (hi[c] && lo[c]) overlap++;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          found;
        logic        prev;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hi", 32'(hi), 32'h0);
        check("rst_lo", 32'(lo), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        wb_rd(32'h00, rd); check("ctrl_rst", rd, 32'h0);

        // Register write / read-back, byte lanes, unmapped space
        wb_wr(32'h04, 32'd9);
        wb_wr(32'h08, 32'd2);
        wb_wr(32'h10, 32'd4);
        wb_rd(32'h04, rd); check("period_rb", rd, 32'd9);
        wb_rd(32'h08, rd); check("deadtime_rb", rd, 32'd2);
        wb_rd(32'h10, rd); check("duty0_rb", rd, 32'd4);
        wb_xfer(1'b1, BASE + 32'h04, 32'h0000_AB12, 4'b0010, rd);
        wb_rd(32'h04, rd); check("period_bytelane", rd, 32'h0000_AB09);
        wb_wr(32'h04, 32'd9);
        wb_wr(32'h40, 32'hFFFF_FFFF);
        wb_rd(32'h40, rd); check("unmapped_rd", rd, 32'h0);
        wb_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd); check("outside_rd", rd, 32'h0);
        wb_rd(32'h04, rd); check("period_after_unmapped", rd, 32'd9);
        measure(10);
        check("idle_gates", 32'(hi_cnt[0] + lo_cnt[0] + hi_cnt[1] + lo_cnt[1]), 32'd0);

        // Basic PWM with no dead time
        wb_wr(32'h08, 32'd0);
        wb_wr(32'h00, 32'h1);
        repeat (25) @(negedge clk);
        measure(10);
        check("basic_hi", 32'(hi_cnt[0]), 32'd4);
        check("basic_lo", 32'(lo_cnt[0]), 32'd6);
        check("basic_overlap", 32'(overlap), 32'd0);

        // Dead time of 2
        wb_wr(32'h08, 32'd2);
        repeat (25) @(negedge clk);
        measure(10);
        check("dt_hi", 32'(hi_cnt[0]), 32'd2);
        check("dt_lo", 32'(lo_cnt[0]), 32'd4);
        check("dt_overlap", 32'(overlap), 32'd0);

        // Shadow update mid-period
        wb_wr(32'h08, 32'd0);
        repeat (20) @(negedge clk);
        found = 1'b0;
        prev  = hi[0];
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (hi[0] && !prev) found = 1'b1;
            prev = hi[0];
        end
        check("shadow_sync", 32'(found), 32'd1);
        runs.delete();
        wb_wr(32'h10, 32'd7);
        lat = 0;
        while (runs.size() < 2 && lat < 40) begin @(negedge clk); lat++; end
        check("shadow_runs", 32'(runs.size() >= 2), 32'd1);
        if (runs.size() >= 2) begin
            check("shadow_cur_period", 32'(runs[0]), 32'd4);
            check("shadow_next_period", 32'(runs[1]), 32'd7);
        end

        // Limits and channel independence
        wb_wr(32'h10, 32'd4);
        wb_wr(32'h14, 32'd0);
        wb_wr(32'h18, 32'd10);
        wb_wr(32'h1C, 32'd7);
        repeat (25) @(negedge clk);
        measure(10);
        check("ch0_hi", 32'(hi_cnt[0]), 32'd4);
        check("ch0_lo", 32'(lo_cnt[0]), 32'd6);
        check("ch1_hi_duty0", 32'(hi_cnt[1]), 32'd0);
        check("ch1_lo_duty0", 32'(lo_cnt[1]), 32'd10);
        check("ch2_hi_full", 32'(hi_cnt[2]), 32'd10);
        check("ch2_lo_full", 32'(lo_cnt[2]), 32'd0);
        check("ch3_hi", 32'(hi_cnt[3]), 32'd7);
        check("ch3_lo", 32'(lo_cnt[3]), 32'd3);

        // Fault shutdown and clear
        check("pre_fault_active", 32'((hi | lo) != '0), 32'd1);
        @(negedge clk);
        fault_in = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (((hi | lo) != '0) && lat < 10);
        check("fault_latency_le3", 32'(lat <= 3), 32'd1);
        wb_rd(32'h0C, rd); check("fault_status", rd & 32'h1, 32'h1);
        check("irq_masked", 32'(irq), 32'd0);
        wb_wr(32'h00, 32'h3);
        check("irq_fault", 32'(irq), 32'd1);
        wb_wr(32'h00, 32'h7);
        wb_rd(32'h0C, rd); check("fault_clr_blocked", rd & 32'h1, 32'h1);
        wb_rd(32'h00, rd); check("ctrl_clr_reads0", rd, 32'h3);
        measure(10);
        check("fault_gates_off", 32'(hi_cnt[0] + lo_cnt[0] + hi_cnt[2] + lo_cnt[1]), 32'd0);
        fault_in = 1'b0;
        repeat (4) @(negedge clk);
        wb_wr(32'h00, 32'h7);
        wb_rd(32'h0C, rd); check("fault_cleared", rd & 32'h1, 32'h0);
        repeat (25) @(negedge clk);
        measure(10);
        check("resume_hi", 32'(hi_cnt[0]), 32'd4);
        check("resume_lo", 32'(lo_cnt[0]), 32'd6);

        // WRAP sticky clear with counter stopped
        wb_wr(32'h00, 32'h2);
        check("irq_wrap", 32'(irq), 32'd1);
        wb_wr(32'h0C, 32'h2);
        wb_rd(32'h0C, rd); check("status_clear", rd, 32'h0);
        check("irq_cleared", 32'(irq), 32'd0);

        // Asynchronous reset mid-operation
        wb_wr(32'h00, 32'h1);
        repeat (5) @(negedge clk);
        check("pre_reset_lo1", 32'(lo[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hi", 32'(hi), 32'h0);
        check("async_rst_lo", 32'(lo), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
